msrv32_decode_stage: RTL and testbench
======================================

MSRV32_DECODE_STAGE -- requirements
Module: msrv32_decode_stage

Interface
REQ-001 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock, rising-edge.
REQ-002 SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port instr_in, input, 32 bits: the fetched instruction.
REQ-004 SHALL have port pc_in, input, 32 bits: the PC of instr_in.
REQ-005 SHALL have port instr_valid_in, input, 1 bit: instr_in and pc_in are valid.
REQ-006 SHALL have port ready_out, output, 1 bit: the stage can accept an instruction this cycle.
REQ-007 SHALL have ports rs1_addr_out and rs2_addr_out, output, 5 bits each: the combinational register-file read addresses, instr_in[19:15] and instr_in[24:20].
REQ-008 SHALL have ports rs1_data_in and rs2_data_in, input, 32 bits each: the register-file read data, valid in the same cycle.
REQ-009 SHALL have ports op_1_out and op_2_out, output, 32 bits each: the registered ALU operands.
REQ-010 SHALL have port alu_opcode_out, output, 4 bits: the registered ALU opcode. Bit 3 selects subtract or arithmetic shift; bits 2:0 carry funct3.
REQ-011 SHALL have port rd_addr_out, output, 5 bits, and port wr_en_out, output, 1 bit: the registered destination register and write enable.
REQ-012 SHALL have port illegal_instr_out, output, 1 bit: the registered instruction is unsupported.
REQ-013 SHALL have port valid_out, output, 1 bit: the output register holds an instruction.
REQ-014 SHALL have port ready_in, input, 1 bit: the downstream stage accepts the held instruction.
REQ-015 SHALL have port flush_in, input, 1 bit: discard the held instruction and the incoming one.
REQ-016 SHALL have port issue_count_out, output, 32 bits: the number of completed downstream transfers.

Function
REQ-017 SHALL drive ready_out = !valid_out || ready_in, combinationally.
REQ-018 SHALL capture on a clock edge when instr_valid_in && ready_out && !flush_in, sampling rs1_data_in and rs2_data_in in that same cycle. valid_out is 1 from the next cycle, giving a latency of 1.
REQ-019 SHALL clear valid_out on an edge where valid_out && ready_in and no capture occurs.
REQ-020 SHALL keep all outputs other than ready_out stable while valid_out && !ready_in.
REQ-021 SHALL, when flush_in = 1, clear valid_out at the next edge and block capture in that cycle. Flush has priority over capture and over transfer.
REQ-022 SHALL decode opcode OP (0110011) as op_1 = rs1_data, op_2 = rs2_data and alu_opcode = {funct7[5], funct3}. funct7 SHALL be 0000000, or 0100000 with funct3 000 or 101.
REQ-023 SHALL decode opcode OP-IMM (0010011) as op_1 = rs1_data and op_2 = the sign-extended imm[11:0].
  - alu_opcode = {instr[30], 101} for funct3 = 101.
  - alu_opcode = {0, funct3} for all other funct3.
  - SLLI requires instr[31:25] = 0000000.
  - SRLI/SRAI require instr[31:25] = 0000000 or 0100000.
  - For shifts, op_2 = {27'b0, shamt}.
REQ-024 SHALL decode LUI (0110111) as op_1 = 0, op_2 = {instr[31:12], 12'b0}, alu_opcode = 0000.
REQ-025 SHALL decode AUIPC (0010111) as op_1 = pc_in, op_2 = the U-immediate, alu_opcode = 0000.
REQ-026 SHALL treat any other opcode or funct7 violation as illegal.
  - illegal_instr_out = 1, wr_en_out = 0, alu_opcode_out = 0000.
  - op_1_out and op_2_out = 0.
  - valid_out behaves normally.
REQ-027 SHALL force wr_en_out = 0 when rd = 0. wr_en_out is otherwise 1 for legal instructions.
REQ-028 SHALL increment issue_count_out by 1 on each edge with valid_out && ready_in && !flush_in, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-029 SHALL, while ms_riscv32_mp_rst_in = 1, immediately force to 0: valid_out, op_1_out, op_2_out, alu_opcode_out, rd_addr_out, wr_en_out, illegal_instr_out and issue_count_out.
REQ-030 SHALL, on reset asserted mid-transfer, drop the held instruction without counting it. The first capture SHALL occur on the first edge after deassertion.

Structure
REQ-031 SHALL take from a shared package msrv32_pkg:
  - the opcode constants OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC;
  - the FUNCT3_* ALU constants;
  - a 4-bit alu_opcode_t typedef.
REQ-032 SHALL instantiate one sub-module, msrv32_imm_gen (combinational I/U-immediate generation).

Verification
REQ-033 SHALL cover: instr 0x002081B3 (ADD x3,x1,x2), rs1=5, rs2=7 -> next cycle valid_out=1, op_1=5, op_2=7, alu_opcode=0000, rd=3, wr_en=1.
REQ-034 SHALL cover: instr 0x40435293 (SRAI x5,x6,4), rs1=0x80000000 -> op_1=0x80000000, op_2=4, alu_opcode=1101.
REQ-035 SHALL cover: instr 0x123450B7 (LUI x1,0x12345) -> op_1=0, op_2=0x12345000, alu_opcode=0000; then instr 0x00001017 (AUIPC x0,1), pc=0x100 -> op_1=0x100, op_2=0x1000, wr_en=0.
REQ-036 SHALL cover: ready_in=0 for 3 cycles with a new instr_valid_in=1 -> ready_out=0 and outputs unchanged; ready_in=1 -> issue_count_out +1 and the new instruction is captured on the same edge.
REQ-037 SHALL cover: instr 0x00000073 (ECALL) -> illegal_instr_out=1, wr_en_out=0; flush_in=1 together with instr_valid_in=1 -> valid_out=0 next cycle, count unchanged.
REQ-038 SHALL cover: reset asserted mid-cycle while valid_out=1 -> all outputs 0 immediately, issue_count_out=0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared RV32 decode constants: base opcodes, ALU funct3 encodings, ALU opcode type.
// Latency: none. It holds only constants and types.
// Backpressure: not applicable.
package msrv32_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SRL  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Bit 3 selects subtract / arithmetic shift; bits 2:0 carry funct3.
    typedef logic [3:0] alu_opcode_t;

endpackage

// File: rtl/msrv32_imm_gen.sv
// Builds the sign-extended I-immediate and the U-immediate from the upper instruction bits.
// Latency: combinational.
// Backpressure: none. Its outputs follow its inputs.
module msrv32_imm_gen (
    input  logic [31:12] instr_upper,
    output logic [31:0]  i_imm,
    output logic [31:0]  u_imm
);

    // I-type immediate is instr[31:20] sign-extended; U-type is instr[31:12] << 12.
    always_comb begin
        i_imm = {{20{instr_upper[31]}}, instr_upper[31:20]};
        u_imm = {instr_upper[31:12], 12'b0};
    end

endmodule

// File: rtl/msrv32_decode_stage.sv
// Decodes RV32 OP / OP-IMM / LUI / AUIPC into registered ALU operands, opcode and writeback info.
// Latency: 1 cycle from an accepted instruction to valid_out.
// Backpressure: holds the output register while ready_in is low. Accepts a new instruction on the same edge the held one leaves.
module msrv32_decode_stage
    import msrv32_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        instr_valid_in,
    output logic        ready_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  alu_opcode_out,
    output logic [4:0]  rd_addr_out,
    output logic        wr_en_out,
    output logic        illegal_instr_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        flush_in,
    output logic [31:0] issue_count_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] i_imm;
    logic [31:0] u_imm;

    logic        dec_legal;
    logic [31:0] dec_op_1;
    logic [31:0] dec_op_2;
    alu_opcode_t dec_alu;

    logic        capture;
    logic        transfer;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];
    assign shamt  = instr_in[24:20];

    assign rs1_addr_out = instr_in[19:15];
    assign rs2_addr_out = instr_in[24:20];

    assign ready_out = !valid_out || ready_in;
    assign capture   = instr_valid_in && ready_out && !flush_in;
    assign transfer  = valid_out && ready_in && !flush_in;

    msrv32_imm_gen u_imm_gen (
        .instr_upper (instr_in[31:12]),
        .i_imm       (i_imm),
        .u_imm       (u_imm)
    );

    // Decode the incoming instruction. Unsupported encodings leave every field at zero.
    always_comb begin
        dec_legal = 1'b0;
        dec_op_1  = 32'h0;
        dec_op_2  = 32'h0;
        dec_alu   = 4'b0000;
        case (opcode)
            OPCODE_OP: begin
                if (funct7 == FUNCT7_BASE ||
                    (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD || funct3 == FUNCT3_SRL))) begin
                    dec_legal = 1'b1;
                    dec_op_1  = rs1_data_in;
                    dec_op_2  = rs2_data_in;
                    dec_alu   = {funct7[5], funct3};
                end
            end
            OPCODE_OP_IMM: begin
                case (funct3)
                    FUNCT3_SLL: begin
                        if (funct7 == FUNCT7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op_1  = rs1_data_in;
                            dec_op_2  = {27'b0, shamt};
                            dec_alu   = {1'b0, funct3};
                        end
                    end
                    FUNCT3_SRL: begin
                        if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op_1  = rs1_data_in;
                            dec_op_2  = {27'b0, shamt};
                            dec_alu   = {instr_in[30], FUNCT3_SRL};
                        end
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op_1  = rs1_data_in;
                        dec_op_2  = i_imm;
                        dec_alu   = {1'b0, funct3};
                    end
                endcase
            end
            OPCODE_LUI: begin
                dec_legal = 1'b1;
                dec_op_2  = u_imm;
            end
            OPCODE_AUIPC: begin
                dec_legal = 1'b1;
                dec_op_1  = pc_in;
                dec_op_2  = u_imm;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Output register. Flush wins over capture and over transfer. Fields change only on capture.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            valid_out         <= 1'b0;
            op_1_out          <= 32'h0;
            op_2_out          <= 32'h0;
            alu_opcode_out    <= 4'b0000;
            rd_addr_out       <= 5'd0;
            wr_en_out         <= 1'b0;
            illegal_instr_out <= 1'b0;
        end else if (flush_in) begin
            valid_out <= 1'b0;
        end else if (capture) begin
            valid_out         <= 1'b1;
            op_1_out          <= dec_op_1;
            op_2_out          <= dec_op_2;
            alu_opcode_out    <= dec_alu;
            rd_addr_out       <= rd;
            wr_en_out         <= dec_legal && (rd != 5'd0);
            illegal_instr_out <= !dec_legal;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

    // Count completed downstream transfers. The counter wraps naturally at 2^32.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            issue_count_out <= 32'h0;
        end else if (transfer) begin
            issue_count_out <= issue_count_out + 32'd1;
        end
    end

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Directed-vector bench for msrv32_decode_stage: decode table plus backpressure, flush and reset sequences.
// Latency: checks outputs 1 ns after the rising edge that follows each applied input.
// Backpressure: ready_in is driven directly by the bench to stall and release the stage.
module tb_msrv32_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid_in;
    logic        ready_out;
    logic [4:0]  rs1_addr_out;
    logic [4:0]  rs2_addr_out;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic [31:0] op_1_out;
    logic [31:0] op_2_out;
    logic [3:0]  alu_opcode_out;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic        illegal_instr_out;
    logic        valid_out;
    logic        ready_in;
    logic        flush_in;
    logic [31:0] issue_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    msrv32_decode_stage dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_in             (instr_in),
        .pc_in                (pc_in),
        .instr_valid_in       (instr_valid_in),
        .ready_out            (ready_out),
        .rs1_addr_out         (rs1_addr_out),
        .rs2_addr_out         (rs2_addr_out),
        .rs1_data_in          (rs1_data_in),
        .rs2_data_in          (rs2_data_in),
        .op_1_out             (op_1_out),
        .op_2_out             (op_2_out),
        .alu_opcode_out       (alu_opcode_out),
        .rd_addr_out          (rd_addr_out),
        .wr_en_out            (wr_en_out),
        .illegal_instr_out    (illegal_instr_out),
        .valid_out            (valid_out),
        .ready_in             (ready_in),
        .flush_in             (flush_in),
        .issue_count_out      (issue_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        instr_in    = v.instr;
        pc_in       = v.pc;
        rs1_data_in = v.rs1;
        rs2_data_in = v.rs2;
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        check({tag, "_op1"}, op_1_out, v.op1);
        check({tag, "_op2"}, op_2_out, v.op2);
        check({tag, "_alu"}, {28'b0, alu_opcode_out}, {28'b0, v.alu});
        check({tag, "_rd"}, {27'b0, rd_addr_out}, {27'b0, v.rd});
        check({tag, "_wr"}, {31'b0, wr_en_out}, {31'b0, v.wr});
        check({tag, "_ill"}, {31'b0, illegal_instr_out}, {31'b0, v.ill});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
        check({tag, "_op1"}, op_1_out, 32'd0);
        check({tag, "_op2"}, op_2_out, 32'd0);
        check({tag, "_alu"}, {28'b0, alu_opcode_out}, 32'd0);
        check({tag, "_rd"}, {27'b0, rd_addr_out}, 32'd0);
        check({tag, "_wr"}, {31'b0, wr_en_out}, 32'd0);
        check({tag, "_ill"}, {31'b0, illegal_instr_out}, 32'd0);
        check({tag, "_cnt"}, issue_count_out, 32'd0);
    endtask

    initial begin
        vec_t add_v;
        vec_t ecall_v;

        //            instr         pc          rs1           rs2          op1           op2           alu    rd  wr    ill
        vecs[0]  = '{32'h002081B3, 32'h0,     32'h5,        32'h7,       32'h5,        32'h7,        4'h0, 5'd3, 1'b1, 1'b0}; // ADD x3,x1,x2
        vecs[1]  = '{32'h40435293, 32'h0,     32'h80000000, 32'h0,       32'h80000000, 32'h4,        4'hD, 5'd5, 1'b1, 1'b0}; // SRAI x5,x6,4
        vecs[2]  = '{32'h123450B7, 32'h0,     32'hDEADBEEF, 32'h0,       32'h0,        32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0}; // LUI x1,0x12345
        vecs[3]  = '{32'h00001017, 32'h100,   32'hDEADBEEF, 32'h1,       32'h100,      32'h1000,     4'h0, 5'd0, 1'b0, 1'b0}; // AUIPC x0,1
        vecs[4]  = '{32'h00000073, 32'h0,     32'h12345678, 32'h9,       32'h0,        32'h0,        4'h0, 5'd0, 1'b0, 1'b1}; // ECALL
        vecs[5]  = '{32'h403100B3, 32'h0,     32'd20,       32'd8,       32'd20,       32'd8,        4'h8, 5'd1, 1'b1, 1'b0}; // SUB x1,x2,x3
        vecs[6]  = '{32'hFFF08113, 32'h0,     32'd10,       32'h0,       32'd10,       32'hFFFFFFFF, 4'h0, 5'd2, 1'b1, 1'b0}; // ADDI x2,x1,-1
        vecs[7]  = '{32'h403110B3, 32'h0,     32'h1,        32'h2,       32'h0,        32'h0,        4'h0, 5'd1, 1'b0, 1'b1}; // SLL with funct7 0100000
        vecs[8]  = '{32'h01F21213, 32'h0,     32'h55,       32'h99,      32'h55,       32'h1F,       4'h1, 5'd4, 1'b1, 1'b0}; // SLLI x4,x4,31
        vecs[9]  = '{32'h41F21213, 32'h0,     32'h55,       32'h99,      32'h0,        32'h0,        4'h0, 5'd4, 1'b0, 1'b1}; // SLLI with funct7 0100000
        vecs[10] = '{32'h7FF04293, 32'h0,     32'h0,        32'h0,       32'h0,        32'h7FF,      4'h4, 5'd5, 1'b1, 1'b0}; // XORI x5,x0,0x7FF
        vecs[11] = '{32'h0033D313, 32'h0,     32'hF0,       32'h0,       32'hF0,       32'h3,        4'h5, 5'd6, 1'b1, 1'b0}; // SRLI x6,x7,3
        vecs[12] = '{32'h022081B3, 32'h0,     32'h5,        32'h7,       32'h0,        32'h0,        4'h0, 5'd3, 1'b0, 1'b1}; // MUL (funct7 0000001)
        vecs[13] = '{32'h0020A3B3, 32'h0,     32'h3,        32'h4,       32'h3,        32'h4,        4'h2, 5'd7, 1'b1, 1'b0}; // SLT x7,x1,x2
        add_v   = vecs[0];
        ecall_v = vecs[4];

        // Reset state.
        rst = 1'b1;
        instr_valid_in = 1'b0;
        ready_in = 1'b1;
        flush_in = 1'b0;
        instr_in = 32'h0;
        pc_in = 32'h0;
        rs1_data_in = 32'h0;
        rs2_data_in = 32'h0;
        #2;
        check_all_zero("reset");
        check("reset_ready", {31'b0, ready_out}, 32'd1);
        #10 rst = 1'b0;
        step();

        // Combinational register-file addresses for ADD x3,x1,x2.
        apply(add_v);
        #1;
        check("rs1_addr", {27'b0, rs1_addr_out}, 32'd1);
        check("rs2_addr", {27'b0, rs2_addr_out}, 32'd2);

        // Decode table, back to back with the sink always ready.
        instr_valid_in = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            step();
            check_fields($sformatf("v%0d", i), vecs[i]);
            check($sformatf("v%0d_cnt", i), issue_count_out, i);
        end

        // Stall for 3 cycles with a new instruction waiting. SLT stays held.
        ready_in = 1'b0;
        apply(add_v);
        #1;
        check("stall_ready", {31'b0, ready_out}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_fields($sformatf("stall%0d", c), vecs[13]);
            check($sformatf("stall%0d_cnt", c), issue_count_out, 32'd13);
        end
        ready_in = 1'b1;
        #1;
        check("release_ready", {31'b0, ready_out}, 32'd1);
        step();
        check_fields("release", add_v);
        check("release_cnt", issue_count_out, 32'd14);

        // ECALL is illegal but still flows.
        apply(ecall_v);
        step();
        check_fields("ecall", ecall_v);
        check("ecall_cnt", issue_count_out, 32'd15);

        // Flush together with a valid incoming instruction: nothing captured, nothing counted.
        flush_in = 1'b1;
        apply(add_v);
        step();
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        check("flush_cnt", issue_count_out, 32'd15);
        check("flush_ill_held", {31'b0, illegal_instr_out}, 32'd1);
        flush_in = 1'b0;
        instr_valid_in = 1'b0;
        step();
        check("idle_valid", {31'b0, valid_out}, 32'd0);
        check("idle_cnt", issue_count_out, 32'd15);

        // Transfer without a new capture clears valid_out.
        instr_valid_in = 1'b1;
        apply(add_v);
        step();
        check_fields("recap", add_v);
        instr_valid_in = 1'b0;
        step();
        check("drain_valid", {31'b0, valid_out}, 32'd0);
        check("drain_cnt", issue_count_out, 32'd16);

        // Reset asserted mid-cycle while an instruction is held with the sink stalled.
        instr_valid_in = 1'b1;
        ready_in = 1'b0;
        apply(vecs[2]);
        step();
        check_fields("prerst", vecs[2]);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        #3 rst = 1'b0;
        ready_in = 1'b1;
        apply(vecs[1]);
        step();
        check_fields("postrst", vecs[1]);
        check("postrst_cnt", issue_count_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
